ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 46 ++++
 rtl/ram_arbiter_byte_merge.sv | 24 ++
 rtl/ram_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the instruction/data RAM arbiter:
//   - default address and data widths
//   - FSM state encoding (also exported on the debug port)
//   - owner encoding for the latched requester
//   - byte-enable pattern constants and the partial-store legality helper
package ram_arbiter_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_RD   = 3'd1,
      MEM_RD  = 3'd2,
      RD_WAIT = 3'd3,
      MEM_WR  = 3'd4,
      RMW_WR  = 3'd5
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam logic [3:0] BE_FULL = 4'b1111;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_H0   = 4'b0011;
   localparam logic [3:0] BE_H1   = 4'b1100;

   // Byte and naturally aligned half-word stores are the only partial
   // writes that go through read-modify-write.
   function automatic logic be_is_partial(input logic [3:0] be);
      logic r;
      r = 1'b0;
      case (be)
         BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1: r = 1'b1;
         default:                                  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// ram_byte_merge
//   Combinational lane merge for read-modify-write stores.
//   Ports:
//     old_i    - word read back from the RAM
//     new_i    - lane-aligned store data
//     be_i     - byte enables, lane 0 = bits 7:0
//     merged_o - per lane: be_i[i] ? new_i lane : old_i lane
module ram_byte_merge #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_i,
   input  logic [DATA_WIDTH-1:0]   new_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic [DATA_WIDTH-1:0]   merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between an instruction-fetch port (read only)
//   and a load/store port. Partial stores are done as read-modify-write.
//   Ports:
//     clk_i, rst_n_i               - clock, async active-low reset
//     if_req_i/if_addr_i           - fetch request and byte address
//     if_ack_o/if_rdata_o          - fetch done pulse and fetched word
//     mem_req_i/we/be/addr/wdata   - load/store request
//     mem_ack_o/mem_rdata_o        - load/store done pulse and loaded word
//     mem_err_o                    - illegal byte-enable pattern (with ack)
//     if_stall_o/mem_stall_o       - request pending and not yet acked
//     ram_ce_o/we/addr/wdata       - registered RAM strobes
//     ram_rdata_i                  - RAM read data, valid cycle after read
//     dbg_state_o                  - current FSM state
//
//   Handshake: a requester raises req and holds it until its ack, a single
//   cycle pulse. The request is latched at grant, so dropping req or
//   changing the inputs after the grant cycle does not affect it.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_ack_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   input  logic                    mem_req_i,
   input  logic                    mem_we_i,
   input  logic [DATA_WIDTH/8-1:0] mem_be_i,
   input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
   input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
   output logic                    mem_ack_o,
   output logic [DATA_WIDTH-1:0]   mem_rdata_o,
   output logic                    mem_err_o,
   output logic                    if_stall_o,
   output logic                    mem_stall_o,
   output logic                    ram_ce_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
   output state_t                  dbg_state_o
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   owner_t                  r_last_grant;
   owner_t                  r_owner;
   logic [DATA_WIDTH/8-1:0] r_be;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_rmw;
   logic                    r_err;
   logic                    r_ram_ce;
   logic                    r_ram_we;
   logic [ADDR_WIDTH-1:0]   r_ram_addr;
   logic [DATA_WIDTH-1:0]   r_ram_wdata;
   logic [DATA_WIDTH-1:0]   r_if_rdata;
   logic [DATA_WIDTH-1:0]   r_mem_rdata;

   logic                    w_grant_mem;
   logic                    w_grant_if;
   logic                    w_store_full;
   logic                    w_store_part;
   logic                    w_store_bad;
   logic                    w_rd_done;
   logic                    w_mem_ld_ack;
   logic                    w_ce_nxt;
   logic                    w_we_nxt;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   logic [DATA_WIDTH-1:0]   w_wdata_nxt;
   logic [DATA_WIDTH-1:0]   w_merged;
   logic                    w_unused_addr_bits;

   // The RAM is word addressed; the byte offset only matters to the mem stage.
   assign w_unused_addr_bits = ^{if_addr_i[1:0], mem_addr_i[1:0]};

   // Both pending: whoever was not granted last wins. last_grant resets to
   // IF so the data side wins the first contention.
   assign w_grant_mem = (r_state == IDLE) && mem_req_i &&
                        (!if_req_i || (r_last_grant == OWN_IF));
   assign w_grant_if  = (r_state == IDLE) && if_req_i && !w_grant_mem;

   assign w_store_full = mem_we_i && (&mem_be_i);
   assign w_store_part = mem_we_i && be_is_partial(mem_be_i);
   assign w_store_bad  = mem_we_i && !w_store_full && !w_store_part;

   ram_byte_merge #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_merge (
      .old_i   (ram_rdata_i),
      .new_i   (r_wdata),
      .be_i    (r_be),
      .merged_o(w_merged)
   );

   // RAM strobes are registered, so they are computed from the state being
   // entered: ce is high exactly during IF_RD, MEM_RD, legal MEM_WR, RMW_WR.
   always_comb begin
      w_state_nxt = r_state;
      w_ce_nxt    = 1'b0;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_ram_addr;
      w_wdata_nxt = r_ram_wdata;
      case (r_state)
         IDLE: begin
            if (w_grant_mem) begin
               w_addr_nxt = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
               if (!mem_we_i || w_store_part) begin
                  w_state_nxt = MEM_RD;
                  w_ce_nxt    = 1'b1;
               end else if (w_store_full) begin
                  w_state_nxt = MEM_WR;
                  w_ce_nxt    = 1'b1;
                  w_we_nxt    = 1'b1;
                  w_wdata_nxt = mem_wdata_i;
               end else begin
                  // Illegal pattern: pass through MEM_WR to ack with error,
                  // without touching the RAM.
                  w_state_nxt = MEM_WR;
               end
            end else if (w_grant_if) begin
               w_state_nxt = IF_RD;
               w_ce_nxt    = 1'b1;
               w_addr_nxt  = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
            end
         end
         IF_RD, MEM_RD: begin
            w_state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (r_rmw) begin
               w_state_nxt = RMW_WR;
               w_ce_nxt    = 1'b1;
               w_we_nxt    = 1'b1;
               w_wdata_nxt = w_merged;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         MEM_WR, RMW_WR: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= IDLE;
         r_last_grant <= OWN_IF;
         r_owner      <= OWN_IF;
         r_be         <= '0;
         r_wdata      <= '0;
         r_rmw        <= 1'b0;
         r_err        <= 1'b0;
         r_ram_ce     <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_if_rdata   <= '0;
         r_mem_rdata  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ram_ce    <= w_ce_nxt;
         r_ram_we    <= w_we_nxt;
         r_ram_addr  <= w_addr_nxt;
         r_ram_wdata <= w_wdata_nxt;
         if (w_grant_mem) begin
            r_owner      <= OWN_MEM;
            r_last_grant <= OWN_MEM;
            r_be         <= mem_be_i;
            r_wdata      <= mem_wdata_i;
            r_rmw        <= w_store_part;
            r_err        <= w_store_bad;
         end else if (w_grant_if) begin
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_IF;
            r_rmw        <= 1'b0;
            r_err        <= 1'b0;
         end
         if (if_ack_o)     r_if_rdata  <= ram_rdata_i;
         if (w_mem_ld_ack) r_mem_rdata <= ram_rdata_i;
      end
   end

   // RD_WAIT of a plain read is the ack cycle; the read word is forwarded
   // straight from the RAM that cycle and held in a register afterwards.
   assign w_rd_done    = (r_state == RD_WAIT) && !r_rmw;
   assign w_mem_ld_ack = w_rd_done && (r_owner == OWN_MEM);

   assign if_ack_o    = w_rd_done && (r_owner == OWN_IF);
   assign mem_ack_o   = (r_owner == OWN_MEM) &&
                        (w_rd_done || (r_state == MEM_WR) || (r_state == RMW_WR));
   assign mem_err_o   = (r_state == MEM_WR) && r_err;
   assign if_rdata_o  = if_ack_o     ? ram_rdata_i : r_if_rdata;
   assign mem_rdata_o = w_mem_ld_ack ? ram_rdata_i : r_mem_rdata;

   assign if_stall_o  = if_req_i  && !if_ack_o;
   assign mem_stall_o = mem_req_i && !mem_ack_o;

   assign ram_ce_o    = r_ram_ce;
   assign ram_we_o    = r_ram_we;
   assign ram_addr_o  = r_ram_addr;
   assign ram_wdata_o = r_ram_wdata;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Bench for ram_arbiter: behavioural RAM, reference memory image,
//   directed scenarios plus randomized single-requester traffic.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [3:0]    mem_be = '0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          mem_err;
   logic          if_stall;
   logic          mem_stall;
   logic          ram_ce;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   state_t        dbg_state;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_ack_o   (if_ack),
      .if_rdata_o (if_rdata),
      .mem_req_i  (mem_req),
      .mem_we_i   (mem_we),
      .mem_be_i   (mem_be),
      .mem_addr_i (mem_addr),
      .mem_wdata_i(mem_wdata),
      .mem_ack_o  (mem_ack),
      .mem_rdata_o(mem_rdata),
      .mem_err_o  (mem_err),
      .if_stall_o (if_stall),
      .mem_stall_o(mem_stall),
      .ram_ce_o   (ram_ce),
      .ram_we_o   (ram_we),
      .ram_addr_o (ram_addr),
      .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata),
      .dbg_state_o(dbg_state)
   );

   // Physical RAM (written by the DUT) and the bench's reference image.
   logic [DW-1:0] tb_mem  [0:255];
   logic [DW-1:0] ref_mem [0:255];

   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) tb_mem[ram_addr[9:2]] <= ram_wdata;
         else        ram_rdata <= tb_mem[ram_addr[9:2]];
      end
   end

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [DW-1:0] exp_q[$];

   bit            if_hold_ok  = 1'b0;
   logic [DW-1:0] if_hold_val = '0;
   bit            mem_hold_ok = 1'b0;
   logic [DW-1:0] mem_hold_val = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic bit ref_partial(input logic [3:0] be);
      return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
             (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100);
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic mem_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit drop);
      int lat;
      int idx;
      bit got;
      bit full;
      bit part;
      bit bad;
      logic [31:0] exp_word;
      idx  = int'(addr[9:2]);
      full = we && (be == 4'b1111);
      part = we && ref_partial(be);
      bad  = we && !full && !part;
      lat  = !we ? 2 : (part ? 3 : 1);
      if (!we) exp_q.push_back(ref_mem[idx]);
      else if (full) ref_mem[idx] = wdata;
      else if (part) ref_mem[idx] = ref_merge(ref_mem[idx], wdata, be);
      exp_word = ref_mem[idx];

      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wdata;
      got = 1'b0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         chk("mem_if_ack_quiet", {31'd0, if_ack}, 32'd0);
         if (bad) chk("mem_bad_no_ce", {31'd0, ram_ce}, 32'd0);
         if (k == 1 && !bad) begin
            chk("mem_ce_n1", {31'd0, ram_ce}, 32'd1);
            chk("mem_we_n1", {31'd0, ram_we}, {31'd0, full});
            chk("mem_addr_n1", ram_addr, {addr[31:2], 2'b00});
            if (full) chk("mem_wdata_full", ram_wdata, wdata);
         end
         if (k == 3 && part) begin
            chk("rmw_ce", {31'd0, ram_ce}, 32'd1);
            chk("rmw_we", {31'd0, ram_we}, 32'd1);
            chk("rmw_wdata", ram_wdata, exp_word);
         end
         if (!drop) chk("mem_stall", {31'd0, mem_stall}, {31'd0, k < lat});
         if (mem_ack) begin
            got = 1'b1;
            chk("mem_lat", k, lat);
            chk("mem_err", {31'd0, mem_err}, {31'd0, bad});
            if (if_hold_ok) chk("if_rdata_hold", if_rdata, if_hold_val);
            if (!we) begin
               chk("mem_load_data", mem_rdata, exp_q.pop_front());
               mem_hold_ok  = 1'b1;
               mem_hold_val = ref_mem[idx];
            end else begin
               mem_hold_ok = 1'b0;
            end
         end
         if (k == 1 && drop) begin
            mem_req = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
            mem_be = 4'($urandom); mem_we = ~we;
         end
      end
      if (!got) chk("mem_ack_timeout", 32'd0, 32'd1);
      mem_req = 1'b0;
      @(negedge clk);
      chk("mem_after_idle", {29'd0, dbg_state}, {29'd0, IDLE});
      chk("mem_after_ce", {31'd0, ram_ce}, 32'd0);
      if (we) chk("ram_content", tb_mem[idx], ref_mem[idx]);
   endtask

   task automatic if_op(input logic [31:0] addr, input bit drop);
      int idx;
      bit got;
      logic [31:0] exp_data;
      idx = int'(addr[9:2]);
      exp_data = ref_mem[idx];
      @(negedge clk);
      if_req = 1'b1; if_addr = addr;
      got = 1'b0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         chk("if_mem_ack_quiet", {31'd0, mem_ack}, 32'd0);
         if (k == 1) begin
            chk("if_ce_n1", {31'd0, ram_ce}, 32'd1);
            chk("if_we_n1", {31'd0, ram_we}, 32'd0);
            chk("if_addr_n1", ram_addr, {addr[31:2], 2'b00});
         end
         if (!drop) chk("if_stall", {31'd0, if_stall}, {31'd0, k < 2});
         if (if_ack) begin
            got = 1'b1;
            chk("if_lat", k, 2);
            chk("if_data", if_rdata, exp_data);
            if (mem_hold_ok) chk("mem_rdata_hold", mem_rdata, mem_hold_val);
            if_hold_ok  = 1'b1;
            if_hold_val = exp_data;
         end
         if (k == 1 && drop) begin
            if_req = 1'b0; if_addr = $urandom;
         end
      end
      if (!got) chk("if_ack_timeout", 32'd0, 32'd1);
      if_req = 1'b0;
      @(negedge clk);
      chk("if_after_ce", {31'd0, ram_ce}, 32'd0);
   endtask

   // Both requesters held: MEM first, then strict alternation, each load
   // taking 2 cycles plus the mandatory IDLE cycle between grants.
   task automatic contention(input logic [31:0] a_mem, input logic [31:0] a_if);
      int acks;
      acks = 0;
      for (int j = 0; j < 6; j++) exp_q.push_back((j % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'b1111; mem_addr = a_mem;
      if_req = 1'b1; if_addr = a_if;
      for (int k = 1; k <= 40 && acks < 6; k++) begin
         @(negedge clk);
         if (if_ack && mem_ack) chk("both_ack", 32'd1, 32'd0);
         if (if_ack || mem_ack) begin
            chk("cont_owner", {31'd0, mem_ack}, exp_q.pop_front());
            chk("cont_cycle", k, 2 + 3 * acks);
            if (mem_ack) chk("cont_mem_data", mem_rdata, ref_mem[a_mem[9:2]]);
            else         chk("cont_if_data", if_rdata, ref_mem[a_if[9:2]]);
            acks++;
         end
      end
      if (acks < 6) chk("cont_timeout", acks, 6);
      mem_req = 1'b0; if_req = 1'b0;
      exp_q.delete();
      mem_hold_ok = 1'b1; mem_hold_val = ref_mem[a_mem[9:2]];
      if_hold_ok  = 1'b1; if_hold_val  = ref_mem[a_if[9:2]];
      @(negedge clk);
   endtask

   task automatic reset_mid_fetch(input logic [31:0] addr);
      @(negedge clk);
      if_req = 1'b1; if_addr = addr;
      @(negedge clk);
      chk("rst_fetch_ce", {31'd0, ram_ce}, 32'd1);
      @(posedge clk);
      #1;
      chk("rst_in_rd_wait", {29'd0, dbg_state}, {29'd0, RD_WAIT});
      rst_n = 1'b0; if_req = 1'b0;
      #1;
      chk("rst_no_if_ack", {31'd0, if_ack}, 32'd0);
      chk("rst_no_mem_ack", {31'd0, mem_ack}, 32'd0);
      chk("rst_ce", {31'd0, ram_ce}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", ram_addr, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
      chk("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_ack", {31'd0, if_ack}, 32'd0);
         chk("rst_hold_ce", {31'd0, ram_ce}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
      chk("post_rst_ce", {31'd0, ram_ce}, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] v;
      logic [3:0]  be;
      logic [3:0]  part_tab [0:5];
      part_tab[0] = 4'b0001; part_tab[1] = 4'b0010; part_tab[2] = 4'b0100;
      part_tab[3] = 4'b1000; part_tab[4] = 4'b0011; part_tab[5] = 4'b1100;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         tb_mem[i] = v;
         ref_mem[i] = v;
      end
      tb_mem[65] = 32'hDEADBEEF; ref_mem[65] = 32'hDEADBEEF;
      tb_mem[64] = 32'h11223344; ref_mem[64] = 32'h11223344;

      #1;
      chk("init_state", {29'd0, dbg_state}, {29'd0, IDLE});
      chk("init_ce", {31'd0, ram_ce}, 32'd0);
      chk("init_addr", ram_addr, 32'd0);
      chk("init_if_ack", {31'd0, if_ack}, 32'd0);
      chk("init_mem_ack", {31'd0, mem_ack}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      contention(32'h0000_0008, 32'h0000_0010);

      mem_op(1'b0, 4'b0000, 32'h0000_0104, 32'd0, 1'b0);
      chk("load_deadbeef", mem_rdata, 32'hDEADBEEF);
      mem_op(1'b1, 4'b0010, 32'h0000_0101, 32'h0000_AB00, 1'b0);
      chk("sb_word", tb_mem[64], 32'h1122AB44);
      v = tb_mem[3];
      mem_op(1'b1, 4'b0101, 32'h0000_000C, 32'h5555_5555, 1'b0);
      chk("bad_be_ram_same", tb_mem[3], v);
      mem_op(1'b1, 4'b0000, 32'h0000_000C, 32'h6666_6666, 1'b0);
      mem_op(1'b1, 4'b1111, 32'h0000_0200, 32'hCAFEF00D, 1'b0);
      mem_op(1'b0, 4'b0000, 32'h0000_0200, 32'd0, 1'b0);
      chk("lw_after_sw", mem_rdata, 32'hCAFEF00D);
      mem_op(1'b0, 4'b1111, 32'h0000_0104, 32'd0, 1'b1);
      if_op(32'h0000_0202, 1'b1);
      mem_op(1'b1, 4'b1100, 32'h0000_0106, 32'hA5A5_0000, 1'b1);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            if_op(32'($urandom_range(0, 1023)), $urandom_range(0, 7) == 0);
         end else begin
            case ($urandom_range(0, 2))
               0:       be = 4'b1111;
               1:       be = part_tab[$urandom_range(0, 5)];
               default: be = 4'($urandom_range(0, 15));
            endcase
            mem_op(1'($urandom_range(0, 1)), be, 32'($urandom_range(0, 1023)),
                   $urandom, $urandom_range(0, 7) == 0);
         end
      end

      reset_mid_fetch(32'h0000_0104);
      if_op(32'h0000_0104, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

endmodule
